// File: rtl/trap_controller.sv
// Trap controller: chooses between exceptions, interrupts and mret, then
// runs the flush/redirect sequence and supplies the trap CSR write data.
module trap_controller #(
    parameter int N            = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  excReq,
    input  logic [N-1:0] excPC,
    input  logic [N-1:0] excTval,
    input  logic [15:0]  irqPending,
    input  logic [15:0]  mieReg,
    input  logic         mstatusMIE,
    input  logic [N-1:0] mtvec,
    input  logic         mretReq,
    input  logic [N-1:0] mepcIn,
    output logic [15:0]  trapTrigger,
    output logic         trapReturn,
    output logic [N-1:0] mcauseOut,
    output logic [N-1:0] mepcOut,
    output logic [N-1:0] mtvalOut,
    output logic         csrTrapWE,
    output logic         flush,
    output logic         redirectValid,
    output logic [N-1:0] redirectPC,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        REDIRECT
    } state_t;

    localparam logic [3:0]   LAST = 4'(FLUSH_CYCLES - 1);
    localparam logic [N-1:0] LOW2 = N'(3);

    state_t       state, state_nx;
    logic [3:0]   cnt, cnt_nx;
    logic [3:0]   cause_q;
    logic         int_q, ret_q;
    logic [N-1:0] pc_q, tval_q, redir_q;

    logic [15:0]  irq_act;
    logic         exc_any, irq_ok, accept;
    logic [3:0]   exc_cause, irq_cause;
    logic [N-1:0] vec_off;

    function automatic logic [3:0] lowest(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Platform interrupt order: external, software, timer, then the rest
    function automatic logic [3:0] irq_pick(input logic [15:0] v);
        logic [3:0] r;
        if (v[11])     r = 4'd11;
        else if (v[3]) r = 4'd3;
        else if (v[7]) r = 4'd7;
        else           r = lowest(v);
        return r;
    endfunction

    always_comb begin
        exc_any   = |excReq;
        irq_act   = irqPending & mieReg;
        irq_ok    = mstatusMIE && (|irq_act);
        exc_cause = lowest(excReq);
        irq_cause = irq_pick(irq_act);
        vec_off   = N'({irq_cause, 2'b00});
        accept    = (state == IDLE) && (exc_any || irq_ok || mretReq);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Trap record; an mret leaves the CSR data untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            cause_q <= 4'd0;
            int_q   <= 1'b0;
            ret_q   <= 1'b0;
            pc_q    <= '0;
            tval_q  <= '0;
            redir_q <= '0;
        end else if (accept) begin
            if (exc_any) begin
                cause_q <= exc_cause;
                int_q   <= 1'b0;
                ret_q   <= 1'b0;
                pc_q    <= excPC;
                tval_q  <= excTval;
                redir_q <= mtvec & ~LOW2;
            end else if (irq_ok) begin
                cause_q <= irq_cause;
                int_q   <= 1'b1;
                ret_q   <= 1'b0;
                pc_q    <= excPC;
                tval_q  <= '0;
                redir_q <= (mtvec & ~LOW2) +
                           ((mtvec[1:0] == 2'b01) ? vec_off : '0);
            end else begin
                ret_q   <= 1'b1;
                redir_q <= mepcIn & ~LOW2;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        trapTrigger   = 16'd0;
        trapReturn    = 1'b0;
        csrTrapWE     = 1'b0;
        flush         = 1'b0;
        redirectValid = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx = 4'd0;
                if (accept) state_nx = FLUSH;
            end
            FLUSH: begin
                flush = 1'b1;
                if (cnt == 4'd0) begin
                    if (ret_q) begin
                        trapReturn = 1'b1;
                    end else begin
                        trapTrigger = 16'd1 << cause_q;
                        csrTrapWE   = 1'b1;
                    end
                end
                if (cnt == LAST) begin
                    state_nx = REDIRECT;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            REDIRECT: begin
                redirectValid = 1'b1;
                state_nx      = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign mcauseOut  = {int_q, {(N-5){1'b0}}, cause_q};
    assign mepcOut    = pc_q & ~LOW2;
    assign mtvalOut   = tval_q;
    assign redirectPC = redir_q;

endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: directed vector table, hand-written
// multi-cycle sequences, and random traffic against a reference model.
module tb_trap_controller;

    localparam int N = 64;
    localparam int F = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  excReq, irqPending, mieReg;
    logic [N-1:0] excPC, excTval, mtvec, mepcIn;
    logic         mstatusMIE, mretReq;
    logic [15:0]  trapTrigger;
    logic         trapReturn, csrTrapWE, flush, redirectValid, busy;
    logic [N-1:0] mcauseOut, mepcOut, mtvalOut, redirectPC;

    int checks = 0;
    int errors = 0;

    trap_controller #(.N(N), .FLUSH_CYCLES(F)) dut (
        .clk(clk), .reset(reset),
        .excReq(excReq), .excPC(excPC), .excTval(excTval),
        .irqPending(irqPending), .mieReg(mieReg),
        .mstatusMIE(mstatusMIE), .mtvec(mtvec),
        .mretReq(mretReq), .mepcIn(mepcIn),
        .trapTrigger(trapTrigger), .trapReturn(trapReturn),
        .mcauseOut(mcauseOut), .mepcOut(mepcOut), .mtvalOut(mtvalOut),
        .csrTrapWE(csrTrapWE), .flush(flush),
        .redirectValid(redirectValid), .redirectPC(redirectPC),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        excReq = 16'd0; irqPending = 16'd0; mieReg = 16'd0;
        mstatusMIE = 1'b0; mretReq = 1'b0;
        excPC = '0; excTval = '0; mtvec = '0; mepcIn = '0;
    endtask

    typedef struct {
        logic [15:0]  exc, irq, msk;
        logic         gie, mret;
        logic [N-1:0] pc, tval, tvec, mepc;
        logic [15:0]  trig;
        logic         ret;
        logic [N-1:0] cause, epc, mtval, redir;
    } vec_t;

    function automatic vec_t mk(
        input logic [15:0] exc, irq, msk, input logic gie, mret,
        input logic [N-1:0] pc, tval, tvec, mepc,
        input logic [15:0] trig, input logic ret,
        input logic [N-1:0] cause, epc, mtval, redir);
        vec_t v;
        v.exc = exc; v.irq = irq; v.msk = msk; v.gie = gie; v.mret = mret;
        v.pc = pc; v.tval = tval; v.tvec = tvec; v.mepc = mepc;
        v.trig = trig; v.ret = ret; v.cause = cause; v.epc = epc;
        v.mtval = mtval; v.redir = redir;
        return v;
    endfunction

    // ---------------- reference model ----------------
    int           ph;
    logic [3:0]   m_cause;
    logic         m_int, m_ret;
    logic [N-1:0] m_pc, m_tval, m_redir;
    int           irq_order [16] = '{11, 3, 7, 0, 1, 2, 4, 5, 6, 8, 9, 10,
                                     12, 13, 14, 15};

    function automatic int exc_pick(input logic [15:0] v);
        for (int k = 0; k < 16; k++) if (v[k]) return k;
        return -1;
    endfunction

    function automatic int irq_pick_m(input logic [15:0] v);
        for (int k = 0; k < 16; k++) if (v[irq_order[k]]) return irq_order[k];
        return -1;
    endfunction

    task automatic model_step();
        int e, i;
        if (reset) begin
            ph = 0; m_cause = 0; m_int = 0; m_ret = 0;
            m_pc = '0; m_tval = '0; m_redir = '0;
        end else if (ph == 0) begin
            e = exc_pick(excReq);
            i = mstatusMIE ? irq_pick_m(irqPending & mieReg) : -1;
            if (e >= 0 || i >= 0) begin
                m_ret = 0;
                m_int = (e < 0);
                m_cause = 4'((e >= 0) ? e : i);
                m_pc = excPC;
                m_tval = (e >= 0) ? excTval : '0;
                m_redir = (mtvec / 4) * 4;
                if (m_int && mtvec[1:0] == 2'b01)
                    m_redir = m_redir + 4 * N'(m_cause);
                ph = 1;
            end else if (mretReq) begin
                m_ret = 1;
                m_redir = (mepcIn / 4) * 4;
                ph = 1;
            end
        end else if (ph == F + 1) begin
            ph = 0;
        end else begin
            ph++;
        end
    endtask

    task automatic model_check();
        logic first;
        first = (ph == 1);
        chk("rnd_busy", 64'(busy), 64'(ph != 0));
        chk("rnd_flush", 64'(flush), 64'(ph >= 1 && ph <= F));
        chk("rnd_rv", 64'(redirectValid), 64'(ph == F + 1));
        chk("rnd_trig", 64'(trapTrigger),
            (first && !m_ret) ? 64'(1) << m_cause : 64'd0);
        chk("rnd_ret", 64'(trapReturn), 64'(first && m_ret));
        chk("rnd_we", 64'(csrTrapWE), 64'(first && !m_ret));
        chk("rnd_mcause", mcauseOut, {m_int, 59'd0, m_cause});
        chk("rnd_mepc", mepcOut, (m_pc / 4) * 4);
        chk("rnd_mtval", mtvalOut, m_tval);
        chk("rnd_redir", redirectPC, m_redir);
    endtask

    vec_t vt[9];

    initial begin
        vt[0] = mk(16'h0024, 0, 0, 0, 0, 'h1002, 'h55, 'h8001, 0,
                   16'h0004, 0, 2, 'h1000, 'h55, 'h8000);
        vt[1] = mk(0, 16'h0888, 16'h0888, 1, 0, 'h2000, 'h77, 'h8001, 0,
                   16'h0800, 0, 64'h8000_0000_0000_000B, 'h2000, 0, 'h802C);
        vt[2] = mk(16'h0008, 16'h0080, 16'h0080, 1, 1, 'h3004, 'h11,
                   'h9000, 'h1234, 16'h0008, 0, 3, 'h3004, 'h11, 'h9000);
        vt[3] = mk(0, 0, 0, 0, 1, 'h10, 'h20, 'h8001, 'h4003,
                   0, 1, 0, 0, 0, 'h4000);
        vt[4] = mk(0, 16'h0088, 16'hFFFF, 1, 0, 'h5007, 'h99, 'h8000, 0,
                   16'h0008, 0, 64'h8000_0000_0000_0003, 'h5004, 0, 'h8000);
        vt[5] = mk(0, 16'h0800, 16'h0800, 0, 1, 'h10, 'h20, 'h8001, 'h5008,
                   0, 1, 0, 0, 0, 'h5008);
        vt[6] = mk(0, 16'h0030, 16'h0020, 1, 0, 'h6000, 'h1, 'h101, 0,
                   16'h0020, 0, 64'h8000_0000_0000_0005, 'h6000, 0, 'h114);
        vt[7] = mk(16'h8000, 0, 0, 0, 0, 'h7001, 'hDEAD, 'hABCD_0003, 0,
                   16'h8000, 0, 15, 'h7000, 'hDEAD, 'hABCD_0000);
        vt[8] = mk(0, 16'h0140, 16'hFFFF, 1, 0, 'h8008, 'h3, 'h201, 0,
                   16'h0040, 0, 64'h8000_0000_0000_0006, 'h8008, 0, 'h218);

        // reset state, with junk on every input
        reset = 1'b1;
        excReq = 16'hFFFF; irqPending = 16'hFFFF; mieReg = 16'hFFFF;
        mstatusMIE = 1'b1; mretReq = 1'b1;
        excPC = '1; excTval = '1; mtvec = '1; mepcIn = '1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_flush", 64'(flush), 0);
        chk("rst_rv", 64'(redirectValid), 0);
        chk("rst_trig", 64'(trapTrigger), 0);
        chk("rst_ret", 64'(trapReturn), 0);
        chk("rst_we", 64'(csrTrapWE), 0);
        chk("rst_mcause", mcauseOut, 0);
        chk("rst_mepc", mepcOut, 0);
        chk("rst_mtval", mtvalOut, 0);
        chk("rst_redir", redirectPC, 0);
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);

        // directed vector table
        foreach (vt[k]) begin
            excReq = vt[k].exc; irqPending = vt[k].irq; mieReg = vt[k].msk;
            mstatusMIE = vt[k].gie; mretReq = vt[k].mret;
            excPC = vt[k].pc; excTval = vt[k].tval;
            mtvec = vt[k].tvec; mepcIn = vt[k].mepc;
            @(negedge clk);
            idle_inputs();
            chk($sformatf("v%0d_trig", k), 64'(trapTrigger), 64'(vt[k].trig));
            chk($sformatf("v%0d_ret", k), 64'(trapReturn), 64'(vt[k].ret));
            chk($sformatf("v%0d_we", k), 64'(csrTrapWE),
                64'(vt[k].trig != 0));
            chk($sformatf("v%0d_flush1", k), 64'(flush), 1);
            chk($sformatf("v%0d_busy", k), 64'(busy), 1);
            if (vt[k].trig != 0) begin
                chk($sformatf("v%0d_mcause", k), mcauseOut, vt[k].cause);
                chk($sformatf("v%0d_mepc", k), mepcOut, vt[k].epc);
                chk($sformatf("v%0d_mtval", k), mtvalOut, vt[k].mtval);
            end
            @(negedge clk);
            chk($sformatf("v%0d_flush2", k), 64'(flush), 1);
            chk($sformatf("v%0d_trig2", k), 64'(trapTrigger), 0);
            chk($sformatf("v%0d_ret2", k), 64'(trapReturn), 0);
            chk($sformatf("v%0d_rv_early", k), 64'(redirectValid), 0);
            @(negedge clk);
            chk($sformatf("v%0d_rv", k), 64'(redirectValid), 1);
            chk($sformatf("v%0d_flush3", k), 64'(flush), 0);
            chk($sformatf("v%0d_redir", k), redirectPC, vt[k].redir);
            @(negedge clk);
            chk($sformatf("v%0d_idle", k), 64'(busy), 0);
            chk($sformatf("v%0d_rv_off", k), 64'(redirectValid), 0);
        end

        // requests while busy and in the redirect cycle are dropped
        excReq = 16'h0002; mtvec = 'h400; excPC = 'h44;
        @(negedge clk);
        chk("busy_trig1", 64'(trapTrigger), 64'h2);
        excReq = 16'h0010; irqPending = 16'h0800; mieReg = 16'h0800;
        mstatusMIE = 1'b1; mretReq = 1'b1;
        @(negedge clk);
        chk("busy_trig2", 64'(trapTrigger), 0);
        excReq = 16'h0020;
        @(negedge clk);
        chk("busy_rv", 64'(redirectValid), 1);
        chk("busy_redir", redirectPC, 'h400);
        irqPending = 16'h0; mstatusMIE = 1'b0;
        excReq = 16'h0040; mretReq = 1'b1;
        @(negedge clk);
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            chk("busy_no_trig", 64'(trapTrigger), 0);
            chk("busy_no_ret", 64'(trapReturn), 0);
            chk("busy_stays_idle", 64'(busy), 0);
            @(negedge clk);
        end

        // reset on the second flush cycle aborts the sequence
        excReq = 16'h0001; mtvec = 'h900;
        @(negedge clk);
        idle_inputs();
        chk("abort_flush1", 64'(flush), 1);
        @(negedge clk);
        chk("abort_flush2", 64'(flush), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 0);
        chk("abort_flush", 64'(flush), 0);
        chk("abort_redir_clr", redirectPC, 0);
        for (int c = 0; c < 4; c++) begin
            chk("abort_no_rv", 64'(redirectValid), 0);
            chk("abort_no_trig", 64'(trapTrigger), 0);
            @(negedge clk);
        end

        // reset wins over a same-cycle request
        reset = 1'b1; excReq = 16'h0008; mretReq = 1'b1; mtvec = 'h100;
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        chk("rstpri_busy", 64'(busy), 0);
        chk("rstpri_trig", 64'(trapTrigger), 0);
        @(negedge clk);
        chk("rstpri_busy2", 64'(busy), 0);
        chk("rstpri_trig2", 64'(trapTrigger), 0);

        // random traffic against the model
        reset = 1'b1;
        model_step();
        @(negedge clk);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            model_check();
            reset = ($urandom_range(0, 60) == 0);
            excReq = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'd0;
            irqPending = 16'($urandom);
            mieReg = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'd0;
            mstatusMIE = 1'($urandom);
            mretReq = ($urandom_range(0, 7) == 0);
            excPC = {$urandom, $urandom};
            excTval = {$urandom, $urandom};
            mtvec = {$urandom, $urandom};
            mepcIn = {$urandom, $urandom};
            model_step();
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have parameter N, default 64, meaning datapath/CSR width.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, meaning pipeline flush length in cycles; legal range 1-15.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port excReq  in  16  synchronous exception requests; bit index = cause code.
REQ-006 SHALL have port excPC  in  N  PC of the committing instruction.
REQ-007 SHALL have port excTval  in  N  trap value for the exception.
REQ-008 SHALL have port irqPending  in  16  level-sensitive interrupt lines (mip).
REQ-009 SHALL have port mieReg  in  16  interrupt enable mask (mie).
REQ-010 SHALL have port mstatusMIE  in  1  global interrupt enable, mstatus bit 3.
REQ-011 SHALL have port mtvec  in  N  trap vector CSR.
REQ-012 SHALL have port mretReq  in  1  mret committing.
REQ-013 SHALL have port mepcIn  in  N  current mepc CSR value.
REQ-014 SHALL have port trapTrigger  out  16  one-hot trap pulse to the privilege/mstatus unit.
REQ-015 SHALL have port trapReturn  out  1  return pulse to the privilege/mstatus unit.
REQ-016 SHALL have ports mcauseOut, mepcOut, mtvalOut  out  N each  CSR write data.
REQ-017 SHALL have port csrTrapWE  out  1  write strobe for mcause/mepc/mtval.
REQ-018 SHALL have ports flush  out  1, redirectValid  out  1, redirectPC  out  N, and busy  out  1.

Function
REQ-019 SHALL implement FSM states IDLE, FLUSH and REDIRECT; busy SHALL be 1 whenever the state is not IDLE.
REQ-020 In IDLE, the accepted event SHALL be chosen in this priority: exception (any excReq bit), then interrupt, then mret.
REQ-021 Exception selection SHALL take the lowest set index of excReq.
REQ-022 An interrupt SHALL be eligible only when mstatusMIE=1 and (irqPending & mieReg)!=0.
REQ-023 Interrupt priority SHALL be 11, then 3, then 7, then remaining set bits lowest index first.
REQ-024 On acceptance, the controller SHALL register cause, interrupt flag, excPC and tval, then enter FLUSH on the next edge.
REQ-025 tval SHALL be excTval for an exception and 0 for an interrupt.
REQ-026 On the first FLUSH cycle only, trapTrigger SHALL be one-hot at the cause index and csrTrapWE SHALL be 1.
REQ-027 mcauseOut SHALL be {intFlag, zeros, cause[3:0]}, with intFlag in bit N-1; mepcOut SHALL be the registered PC with bits [1:0] cleared; mtvalOut SHALL be the registered tval.
REQ-028 flush SHALL be 1 for exactly FLUSH_CYCLES cycles in FLUSH, then the FSM SHALL enter REDIRECT for exactly one cycle with redirectValid=1, then return to IDLE.
REQ-029 For a trap, redirectPC SHALL be {mtvec[N-1:2],2'b00}; if mtvec[1:0]==01 and the trap is an interrupt, 4*cause SHALL be added.
REQ-030 An accepted mret SHALL sample mepcIn, pulse trapReturn on the first FLUSH cycle only, and leave trapTrigger and csrTrapWE at 0.
REQ-031 For mret, redirectPC SHALL be the sampled mepcIn with bits [1:0] cleared.
REQ-032 excReq, irqPending and mretReq SHALL be ignored (not latched) while busy.
REQ-033 Requests arriving in the REDIRECT cycle SHALL be lost.
REQ-034 redirectPC and the CSR data outputs SHALL be stable throughout FLUSH and REDIRECT.
REQ-035 A mret that coincides with any trap SHALL be dropped.

Reset
REQ-036 reset SHALL force state to IDLE, the flush counter to 0, and every output to 0.
REQ-037 Reset asserted mid-FLUSH or mid-REDIRECT SHALL abort the sequence, with no further pulse or redirect.
REQ-038 Reset SHALL have priority over any same-cycle request.

Verification
REQ-039 SHALL cover: excReq=0x0024, excPC=0x1002, mtvec=0x8001 -> next cycle trapTrigger=0x0004, mcauseOut=2, mepcOut=0x1000; flush high 2 cycles; redirectPC=0x8000.
REQ-040 SHALL cover: mstatusMIE=1, irqPending=mieReg=0x0888, mtvec=0x8001 -> cause 11, mcauseOut bit63=1, redirectPC=0x802C, mtvalOut=0.
REQ-041 SHALL cover: excReq=0x0008, irqPending=mieReg=0x0080, mretReq=1 together -> exception cause 3 taken, trapReturn stays 0 throughout.
REQ-042 SHALL cover: mretReq=1, mepcIn=0x4003 -> trapReturn single pulse, redirectPC=0x4000, csrTrapWE=0.
REQ-043 SHALL cover: excReq pulse while busy -> ignored, with no second trapTrigger after return to IDLE.
REQ-044 SHALL cover: reset on the second FLUSH cycle -> next cycle busy=0, flush=0, and redirectValid is never asserted.
